// File: rtl/compensation_memory_ctrl_if.sv
// Bundle of the signals between the compensation-memory sequencer, the pre-load
// weight stream, the array consumer and the compensation memory itself.
interface compensation_memory_ctrl_if #(
    parameter int SIZE = 8
);
    localparam int CMEM_SIZE       = SIZE * 3;
    localparam int CMEM_ADDR_WIDTH = $clog2(CMEM_SIZE);

    logic                       load_start;
    logic                       in_valid;
    logic [3:0]                 in_data;
    logic                       in_ready;
    logic                       rd_start;
    logic                       cw_ready;
    logic [3:0]                 Compensation_Weight;
    logic [CMEM_ADDR_WIDTH-1:0] Wr_Addr;
    logic                       Wr_en;
    logic [1:0]                 Rd_Addr;
    logic                       Rd_en;
    logic                       cw_valid;
    logic [1:0]                 cw_slot;
    logic                       loaded;
    logic                       busy;
    logic                       rd_done;

    // master: the sequencer, which drives the memory and status lines
    modport master (
        input  load_start, in_valid, in_data, rd_start, cw_ready,
        output in_ready, Compensation_Weight, Wr_Addr, Wr_en, Rd_Addr, Rd_en,
               cw_valid, cw_slot, loaded, busy, rd_done
    );

    modport slave (
        output load_start, in_valid, in_data, rd_start, cw_ready,
        input  in_ready, Compensation_Weight, Wr_Addr, Wr_en, Rd_Addr, Rd_en,
               cw_valid, cw_slot, loaded, busy, rd_done
    );
endinterface

// File: rtl/compensation_memory_ctrl.sv
// Sequencer for the compensation-weight memory: loads SIZE*3 weights from a stream,
// then plays out the three compensation rows to the array under back-pressure.
module compensation_memory_ctrl #(
    parameter int SIZE = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    compensation_memory_ctrl_if.master bus
);
    localparam int CMEM_SIZE       = SIZE * 3;
    localparam int CMEM_ADDR_WIDTH = $clog2(CMEM_SIZE);
    localparam logic [CMEM_ADDR_WIDTH-1:0] LAST_ADDR = CMEM_ADDR_WIDTH'(CMEM_SIZE - 1);

    typedef enum logic [1:0] {IDLE, LOAD, LOADED, READ} state_t;

    state_t                     state_reg, state_next;
    logic [CMEM_ADDR_WIDTH-1:0] wr_cnt_reg, wr_cnt_next;
    logic [1:0]                 issue_cnt_reg, issue_cnt_next;
    logic                       wr_fire, rd_fire;

    logic                       wr_en_reg;
    logic [CMEM_ADDR_WIDTH-1:0] wr_addr_reg;
    logic [3:0]                 wr_data_reg;
    logic                       rd_en_reg;
    logic [1:0]                 rd_addr_reg;
    logic                       cw_valid_reg;
    logic [1:0]                 cw_slot_reg;
    logic                       rd_done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            wr_cnt_reg    <= '0;
            issue_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            wr_cnt_reg    <= wr_cnt_next;
            issue_cnt_reg <= issue_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wr_cnt_next    = wr_cnt_reg;
        issue_cnt_next = issue_cnt_reg;
        wr_fire        = 1'b0;
        rd_fire        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.load_start) begin
                    state_next  = LOAD;
                    wr_cnt_next = '0;
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    wr_fire = 1'b1;
                    if (wr_cnt_reg == LAST_ADDR) begin
                        state_next  = LOADED;
                        wr_cnt_next = '0;
                    end else begin
                        wr_cnt_next = wr_cnt_reg + 1'b1;
                    end
                end
            end
            LOADED: begin
                // A new load invalidates the held set, so it takes priority over read-out
                if (bus.load_start) begin
                    state_next  = LOAD;
                    wr_cnt_next = '0;
                end else if (bus.rd_start) begin
                    state_next     = READ;
                    issue_cnt_next = '0;
                end
            end
            READ: begin
                if (bus.cw_ready && issue_cnt_reg != 2'd3) begin
                    rd_fire        = 1'b1;
                    issue_cnt_next = issue_cnt_reg + 2'd1;
                    if (issue_cnt_reg == 2'd2) begin
                        state_next = LOADED;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory-side strobes are registered; address/data hold between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            rd_en_reg    <= 1'b0;
            rd_addr_reg  <= '0;
            cw_valid_reg <= 1'b0;
            cw_slot_reg  <= '0;
            rd_done_reg  <= 1'b0;
        end else begin
            wr_en_reg <= wr_fire;
            if (wr_fire) begin
                wr_addr_reg <= wr_cnt_reg;
                wr_data_reg <= bus.in_data;
            end
            rd_en_reg <= rd_fire;
            if (rd_fire) begin
                rd_addr_reg <= issue_cnt_reg;
            end
            // The memory's registered read makes the row valid one cycle after Rd_en
            cw_valid_reg <= rd_en_reg;
            if (rd_en_reg) begin
                cw_slot_reg <= rd_addr_reg;
            end
            rd_done_reg <= rd_en_reg && (rd_addr_reg == 2'd2);
        end
    end

    assign bus.in_ready            = (state_reg == LOAD);
    assign bus.busy                = (state_reg == LOAD) || (state_reg == READ);
    assign bus.loaded              = (state_reg == LOADED) || (state_reg == READ);
    assign bus.Wr_en               = wr_en_reg;
    assign bus.Wr_Addr             = wr_addr_reg;
    assign bus.Compensation_Weight = wr_data_reg;
    assign bus.Rd_en               = rd_en_reg;
    assign bus.Rd_Addr             = rd_addr_reg;
    assign bus.cw_valid            = cw_valid_reg;
    assign bus.cw_slot             = cw_slot_reg;
    assign bus.rd_done             = rd_done_reg;
endmodule

// File: tb/tb_compensation_memory_ctrl.sv
// Directed and randomized checks of compensation_memory_ctrl against a
// transaction-level reference model of the load / read-out sequencing.
module tb_compensation_memory_ctrl;
    localparam int SIZE = 8;
    localparam int N    = SIZE * 3;

    // reference model modes
    localparam int M_IDLE = 0, M_LOAD = 1, M_LOADED = 2, M_READ = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    compensation_memory_ctrl_if #(.SIZE(SIZE)) bus();

    compensation_memory_ctrl #(.SIZE(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int   m_mode = M_IDLE;
    int   m_wcount = 0;
    int   m_issues = 0;
    logic e_wr_en = 1'b0;
    int   e_wr_addr = 0;
    int   e_wdata = 0;
    logic e_rd_en = 1'b0;
    int   e_rd_addr = 0;
    logic e_cwv = 1'b0;
    int   e_slot = 0;
    logic e_done = 1'b0;
    int   done_seen = 0;
    int   hs_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Predict what the outputs must look like after the next rising edge.
    task automatic model_step();
        int pend_rd_addr;
        logic pend_rd_en;
        pend_rd_en   = e_rd_en;
        pend_rd_addr = e_rd_addr;
        if (rst) begin
            m_mode = M_IDLE; m_wcount = 0; m_issues = 0;
            e_wr_en = 1'b0; e_rd_en = 1'b0; e_cwv = 1'b0; e_done = 1'b0;
            e_wr_addr = 0; e_wdata = 0; e_rd_addr = 0; e_slot = 0;
            return;
        end
        e_wr_en = 1'b0;
        e_rd_en = 1'b0;
        e_cwv   = pend_rd_en;
        if (pend_rd_en) e_slot = pend_rd_addr;
        e_done  = pend_rd_en && (pend_rd_addr == 2);
        case (m_mode)
            M_IDLE: if (bus.load_start) begin m_mode = M_LOAD; m_wcount = 0; end
            M_LOAD: if (bus.in_valid) begin
                e_wr_en = 1'b1; e_wr_addr = m_wcount; e_wdata = int'(bus.in_data);
                m_wcount++;
                if (m_wcount == N) m_mode = M_LOADED;
            end
            M_LOADED: begin
                if (bus.load_start) begin m_mode = M_LOAD; m_wcount = 0; end
                else if (bus.rd_start) begin m_mode = M_READ; m_issues = 0; end
            end
            default: if (bus.cw_ready) begin
                e_rd_en = 1'b1; e_rd_addr = m_issues;
                m_issues++;
                if (m_issues == 3) m_mode = M_LOADED;
            end
        endcase
    endtask

    task automatic check_outputs();
        chk("in_ready", bus.in_ready, m_mode == M_LOAD);
        chk("busy", bus.busy, m_mode == M_LOAD || m_mode == M_READ);
        chk("loaded", bus.loaded, m_mode == M_LOADED || m_mode == M_READ);
        chk("Wr_en", bus.Wr_en, e_wr_en);
        if (e_wr_en) begin
            chk("Wr_Addr", bus.Wr_Addr, e_wr_addr);
            chk("Compensation_Weight", bus.Compensation_Weight, e_wdata);
        end
        chk("Rd_en", bus.Rd_en, e_rd_en);
        if (e_rd_en) chk("Rd_Addr", bus.Rd_Addr, e_rd_addr);
        chk("cw_valid", bus.cw_valid, e_cwv);
        if (e_cwv) chk("cw_slot", bus.cw_slot, e_slot);
        chk("rd_done", bus.rd_done, e_done);
        chk("wr_rd_exclusive", bus.Wr_en && bus.Rd_en, 1'b0);
    endtask

    // One clock: model predicts, edge happens, outputs checked half a cycle later.
    task automatic tick();
        if (!rst && m_mode == M_LOAD && bus.in_valid) hs_seen++;
        model_step();
        @(posedge clk);
        @(negedge clk);
        if (bus.rd_done === 1'b1) done_seen++;
        check_outputs();
        $display("cyc rst=%0b ls=%0b iv=%0b d=%0d rs=%0b cr=%0b | wr=%0b wa=%0d rd=%0b ra=%0d v=%0b s=%0d done=%0b ld=%0b",
                 rst, bus.load_start, bus.in_valid, bus.in_data, bus.rd_start, bus.cw_ready,
                 bus.Wr_en, bus.Wr_Addr, bus.Rd_en, bus.Rd_Addr, bus.cw_valid, bus.cw_slot,
                 bus.rd_done, bus.loaded);
    endtask

    task automatic quiet();
        bus.load_start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 4'd0;
        bus.rd_start = 1'b0;   bus.cw_ready = 1'b0;
    endtask

    initial begin
        int guard;
        int done_before;
        logic [4:0] pat;
        quiet();
        @(negedge clk);

        // reset then first load command
        rst = 1'b1;
        tick(); tick();
        chk("rst_Wr_Addr", bus.Wr_Addr, 0);
        chk("rst_weight", bus.Compensation_Weight, 0);
        chk("rst_Rd_Addr", bus.Rd_Addr, 0);
        chk("rst_cw_slot", bus.cw_slot, 0);
        rst = 1'b0;
        bus.load_start = 1'b1;
        tick();
        chk("start_in_ready", bus.in_ready, 1'b1);
        chk("start_busy", bus.busy, 1'b1);

        // full load, continuous stream, value = index mod 16
        bus.load_start = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.in_data = 4'(i % 16);
            tick();
        end
        chk("full_load_loaded", bus.loaded, 1'b1);
        chk("full_load_last_addr", bus.Wr_Addr, N - 1);
        quiet();
        tick();

        // read-out with cw_ready stalls 1,0,0,1,1
        done_before = done_seen;
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        pat = 5'b11001;
        for (int i = 0; i < 5; i++) begin
            bus.cw_ready = pat[i];
            tick();
        end
        bus.cw_ready = 1'b0;
        tick(); tick();
        chk("stall_done_count", done_seen - done_before, 1);
        chk("stall_loaded", bus.loaded, 1'b1);

        // throttled load with ignored rd_start / load_start inside LOAD
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        guard = 0;
        while (m_mode == M_LOAD && guard < 200) begin
            bus.in_valid   = guard[0];
            bus.in_data    = 4'($urandom);
            bus.rd_start   = ($urandom_range(0, 3) == 0);
            bus.load_start = ($urandom_range(0, 4) == 0);
            tick();
            guard++;
        end
        chk("throttle_finished", bus.loaded, 1'b1);
        quiet();
        tick();

        // read-out with random back-pressure and ignored load_start
        done_before = done_seen;
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        guard = 0;
        while (m_mode == M_READ && guard < 100) begin
            bus.cw_ready   = ($urandom_range(0, 2) == 0);
            bus.load_start = ($urandom_range(0, 3) == 0);
            tick();
            guard++;
        end
        quiet();
        tick(); tick();
        chk("rand_read_done_count", done_seen - done_before, 1);

        // colliding pulses in LOADED: load wins
        bus.load_start = 1'b1;
        bus.rd_start = 1'b1;
        tick();
        chk("collide_loaded", bus.loaded, 1'b0);
        chk("collide_in_ready", bus.in_ready, 1'b1);

        // reset after 10 handshakes, then restart at address 0
        quiet();
        hs_seen = 0;
        guard = 0;
        while (hs_seen < 10 && guard < 100) begin
            bus.in_valid = ($urandom_range(0, 1) == 1);
            bus.in_data  = 4'($urandom);
            bus.cw_ready = 1'b1;
            tick();
            guard++;
        end
        quiet();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_loaded", bus.loaded, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 4'd9;
        tick();
        chk("restart_Wr_en", bus.Wr_en, 1'b1);
        chk("restart_Wr_Addr", bus.Wr_Addr, 0);

        // random soak
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(0, 150) == 0);
            bus.load_start = ($urandom_range(0, 25) == 0);
            bus.rd_start   = ($urandom_range(0, 6) == 0);
            bus.in_valid   = ($urandom_range(0, 1) == 1);
            bus.in_data    = 4'($urandom);
            bus.cw_ready   = ($urandom_range(0, 1) == 1);
            tick();
        end
        rst = 1'b0;
        quiet();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
